serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial unsigned subtractor: result = a - b, with a borrow-out.
//   It is the inverse-direction counterpart to the parallel RCA adder in the ALU datapath.
//   It takes SIZE-bit operands through a valid/ready handshake.
//   It resolves one bit per clock, LSB first, through a single 1-bit full-subtractor cell.
//   It returns {borrow, difference} through a valid/ready handshake.
//   Used in the 8-bit ALU where area matters more than latency.
// PARAMETERS
//   SIZE  8  operand width in bits; legal range >= 1 (SIZE=1 must work)
// PORTS
//   clk        in   1       clock; all state changes on rising edge
//   rst        in   1       synchronous, active-high reset
//   in_valid   in   1       operands a/b valid
//   in_ready   out  1       block can accept operands
//   a          in   SIZE    minuend, unsigned
//   b          in   SIZE    subtrahend, unsigned
//   out_valid  out  1       result valid
//   out_ready  in   1       consumer accepts result
//   result     out  SIZE+1  {borrow_out, (a-b) mod 2^SIZE}
//   busy       out  1       high in SHIFT or DONE
// BEHAVIOUR
//   - Clock and reset:
//     - Single clock: clk.
//     - Reset is synchronous and active-high on rst.
//   - Reset values:
//     - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
//     - result = 0, internal borrow = 0, bit counter = 0.
//   - Reset mid-operation: any in-flight operation is aborted.
//     - No out_valid is produced for the aborted operation.
//     - Reset values apply on the following cycle.
//   - FSM states: IDLE, SHIFT, DONE.
//   - IDLE:
//     - in_ready = 1.
//     - On in_valid at a clock edge:
//       - latch a and b into shift registers;
//       - borrow := 0, count := 0;
//       - go to SHIFT.
//   - SHIFT:
//     - in_ready = 0.
//     - Each cycle, with x = a_sr[0], y = b_sr[0]:
//       - d = x ^ y ^ bw;
//       - bw' = (~x & y) | (~(x ^ y) & bw).
//     - Shift d into the diff register from the MSB side, so bit i lands in result[i] after SIZE shifts.
//     - Shift a_sr and b_sr right by 1; count++.
//     - When count == SIZE-1 at a clock edge:
//       - the final bit is shifted;
//       - result[SIZE] := bw';
//       - go to DONE.
//   - DONE:
//     - out_valid = 1.
//     - result is held stable until out_valid & out_ready.
//     - On that handshake edge: go to IDLE.
//   - Latency: the in handshake at edge E0 gives out_valid = 1 from edge E0+SIZE onward.
//     - Example: SIZE=8 gives 8 cycles.
//   - Throughput: one operation per SIZE+2 cycles with out_ready held high.
//   - No overlap:
//     - in_ready = 0 in DONE, even when out_ready = 1.
//     - A new operand presented in DONE is taken in the next IDLE cycle.
//   - Operand change after the handshake has no effect; a/b are only sampled in IDLE.
//   - result is unchanged in IDLE after the handshake; it holds the last value until the next DONE.
//   - Arithmetic:
//     - result[SIZE-1:0] = (a - b) mod 2^SIZE.
//     - result[SIZE] = 1 iff a < b (unsigned).
//     - Equal operands give all zeros.
//   - SIZE=1:
//     - counter width is max(1, $clog2(SIZE));
//     - exactly one SHIFT cycle.
// STRUCTURE
//   - alu_pkg:
//     - typedef enum logic[1:0] {IDLE, SHIFT, DONE} serial_state_t;
//     - shared SIZE default constant ALU_WIDTH = 8.
//   - Sub-module full_subtractor: 1-bit cell (x, y, bin -> d, bout).
//     - Instantiated once.
//     - Combinational.
//   - Remaining datapath in this module: two operand shift regs, diff shift reg, borrow flop, counter.
// TESTING
//   - 1. SIZE=8, a=5, b=3, out_ready=1 -> out_valid 8 cycles after accept; result=9'b0_0000_0010.
//   - 2. a=3, b=5 -> result=9'b1_1111_1110; a=0, b=255 -> 9'b1_0000_0001; a=255, b=255 -> 9'h000.
//   - 3. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, result stable, in_ready=0.
//     - Then out_ready=1 -> IDLE next cycle.
//   - 4. Reset asserted in the 4th SHIFT cycle -> next cycle: IDLE, in_ready=1, out_valid=0, result=0.
//     - The next operation computes correctly.
//   - 5. Back-to-back: in_valid held high with new operands -> second op is accepted the cycle after the DONE handshake.
//     - Both results are correct.
//   - 6. SIZE=1 exhaustive over all 4 (a,b) pairs, checked against a-b -> {0,0}=00, {1,0}=01, {0,1}=11, {1,1}=00.
//     - Latency is 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, serial FSM states and a
// counter-width helper used by the bit-serial blocks.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } serial_state_t;

  // A bit counter needs at least one bit, even for a 1-bit datapath.
  function automatic int cnt_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full-subtractor cell: d = x - y - bin, with borrow-out bout.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: result = {borrow, a - b}, one bit per clock,
// LSB first, through a single full-subtractor cell.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int SIZE = ALU_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE:0]   result,
  output logic            busy
);

  localparam int                CNT_W = cnt_width(SIZE);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(SIZE - 1);

  serial_state_t   r_state;
  serial_state_t   w_next_state;
  logic [SIZE-1:0] r_a_sr;
  logic [SIZE-1:0] r_b_sr;
  logic [SIZE-1:0] r_diff;
  logic [SIZE-1:0] w_diff_next;
  logic [SIZE:0]   r_result;
  logic [CNT_W-1:0] r_count;
  logic            r_borrow;
  logic            w_d;
  logic            w_bout;
  logic            w_last;

  full_subtractor u_full_subtractor (
    .x    (r_a_sr[0]),
    .y    (r_b_sr[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last = (r_count == LAST);

  // Written as shift-then-overwrite so the SIZE=1 case needs no special slice.
  always_comb begin
    w_diff_next           = r_diff >> 1;
    w_diff_next[SIZE-1]   = w_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next_state = SHIFT;
      SHIFT:   if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      SHIFT:   busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_diff   <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_count  <= '0;
            r_borrow <= 1'b0;
          end
        end
        SHIFT: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_diff   <= w_diff_next;
          r_borrow <= w_bout;
          r_count  <= r_count + 1'b1;
          // The published result only changes on the final bit, so it stays
          // stable through DONE and the following IDLE.
          if (w_last) r_result <= {w_bout, w_diff_next};
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: SIZE=8 instance driven through a
// scoreboard queue, plus a SIZE=1 instance checked exhaustively.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] a, b;
  logic [W:0]   result;

  logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [0:0]   a1, b1;
  logic [1:0]   result1;

  int n_checks = 0;
  int n_errors = 0;

  logic [W:0] exp_q[$];
  logic [1:0] exp1_q[$];

  serial_subtractor #(.SIZE(W)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  serial_subtractor #(.SIZE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: 9-bit two's-complement difference; bit W is the borrow.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    check("out_valid_wait", out_valid, 1);
  endtask

  task automatic pop_check(input string tag);
    logic [W:0] e;
    check({tag, "_sb_size"}, exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, result, e);
    end
  endtask

  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y);
    wait_ready();
    a        = x;
    b        = y;
    in_valid = 1'b1;
    exp_q.push_back(model(x, y));
    step();
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    check("accept_busy", busy, 1);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
    int         lat;
    logic [W:0] saved;
    out_ready = 1'b0;
    accept(x, y);
    wait_done(lat);
    check("latency", lat, W);
    pop_check("result");
    saved = result;
    for (int i = 0; i < hold; i++) begin
      step();
      check("bp_out_valid", out_valid, 1);
      check("bp_result_stable", result, saved);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_result_held", result, saved);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int bad;

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
    step();
    step();
    rst = 1'b0;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst1_in_ready", in_ready1, 1);
    check("rst1_result", result1, 0);

    // Basic arithmetic, including borrow and equal operands.
    run_op(8'd5, 8'd3, 0);
    check("five_minus_three", result, 9'b0_0000_0010);
    run_op(8'd3, 8'd5, 0);
    check("three_minus_five", result, 9'b1_1111_1110);
    run_op(8'd0, 8'd255, 0);
    check("zero_minus_max", result, 9'b1_0000_0001);
    run_op(8'd255, 8'd255, 0);
    check("equal_operands", result, 9'h000);
    for (int i = 0; i < 4; i++) run_op(W'($urandom), W'($urandom), 0);

    // Backpressure held for five DONE cycles.
    run_op(8'd200, 8'd17, 5);

    // Reset during the 4th SHIFT cycle aborts the operation.
    accept(8'hA5, 8'h3C);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    bad = 0;
    for (int i = 0; i < W + 2; i++) begin
      step();
      if (out_valid) bad++;
    end
    check("abort_no_out_valid", bad, 0);
    run_op(8'hA5, 8'h3C, 0);

    // Back-to-back: in_valid stays high with the next operands.
    wait_ready();
    a = 8'd10; b = 8'd20; in_valid = 1'b1;
    exp_q.push_back(model(8'd10, 8'd20));
    step();
    a = 8'd100; b = 8'd7;
    out_ready = 1'b1;
    wait_done(lat);
    check("b2b_latency0", lat, W);
    check("b2b_done_in_ready", in_ready, 0);
    pop_check("b2b_result0");
    step();
    check("b2b_idle_in_ready", in_ready, 1);
    check("b2b_idle_out_valid", out_valid, 0);
    exp_q.push_back(model(8'd100, 8'd7));
    step();
    in_valid = 1'b0;
    check("b2b_accept_busy", busy, 1);
    check("b2b_accept_in_ready", in_ready, 0);
    wait_done(lat);
    check("b2b_latency1", lat, W);
    pop_check("b2b_result1");
    step();
    out_ready = 1'b0;
    check("b2b_final_idle", in_ready, 1);

    // SIZE=1 exhaustive.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] e;
      logic [1:0] pair;
      pair = 2'(i);
      a1 = pair[0];
      b1 = pair[1];
      in_valid1 = 1'b1;
      exp1_q.push_back({1'b0, a1} - {1'b0, b1});
      step();
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 20) begin
        step();
        lat++;
      end
      check("s1_latency", lat, 1);
      check("s1_sb_size", exp1_q.size(), 1);
      if (exp1_q.size() != 0) begin
        e = exp1_q.pop_front();
        check("s1_result", result1, e);
      end
      out_ready1 = 1'b1;
      step();
      out_ready1 = 1'b0;
      check("s1_idle", in_ready1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
